scope_trigger_ctrl: RTL and testbench
=====================================

# scope_trigger_ctrl

Capture sequencer for the oscilloscope sample buffer. Runs on CLOCK_50 and watches the incoming signed sample stream (the same stream that feeds the display buffer, e.g. ifft_I). It detects a level/slope trigger and writes a fixed pre-trigger plus post-trigger window into a circular buffer. It then freezes that buffer until the display signals end of frame, giving the VGA reader a stable, trigger-aligned trace instead of a free-running one.

## Interface
Parameters:
- DW, 8, sample width (signed two's complement)
- AW, 8, buffer address width; DEPTH = 2^AW
- PRE, 64, pre-trigger samples stored ahead of the trigger sample (1 ≤ PRE ≤ DEPTH-2)
- AUTO_TO, 4096, valid samples spent in ARMED before a forced trigger when auto_mode=1

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = acquire continuously; 0 = stop (SW0)
- auto_mode  in  1  1 = force a trigger after AUTO_TO samples without one
- trig_slope  in  1  0 = rising edge, 1 = falling edge
- trig_level  in  DW  signed trigger threshold
- sample_valid  in  1  sample_in is valid this cycle
- sample_in  in  DW  signed input sample
- frame_done  in  1  one-cycle pulse from display at end of frame, already synchronous to CLOCK_50
- wr_en  out  1  buffer write strobe
- wr_addr  out  AW  buffer write address
- wr_data  out  DW  buffer write data
- capture_ready  out  1  buffer frozen and holds a complete window
- start_addr  out  AW  address of the oldest sample in the frozen window (trigger address − PRE, mod DEPTH)
- trig_forced  out  1  the current/last capture came from the auto timeout
- state_o  out  3  current state: IDLE=0, PREFILL=1, ARMED=2, POST=3, HOLD=4

## Operation
- States:
  - IDLE: no writes. Go to PREFILL when run=1.
  - PREFILL: write every valid sample. After PRE samples, go to ARMED.
  - ARMED: write every valid sample.
    - Rising trigger (slope=0): prev < level and sample_in ≥ level.
    - Falling trigger (slope=1): prev > level and sample_in ≤ level.
    - prev is the last valid sample accepted in PREFILL or ARMED. Comparisons are signed.
    - On trigger: latch trig_addr = the address this sample is written to, and go to POST.
    - If auto_mode=1 and AUTO_TO valid samples are accepted in ARMED with no trigger, the AUTO_TO-th sample acts as the trigger sample and trig_forced is set. A real trigger on that same sample wins, and trig_forced stays 0.
  - POST: write DEPTH−PRE−1 further valid samples. On accepting the last one, go to HOLD.
  - HOLD: no writes. start_addr = trig_addr − PRE (mod DEPTH). Leave to PREFILL on a frame_done pulse only if run=1. With run=0, stay in HOLD indefinitely (single-shot freeze).
- run=0 in PREFILL, ARMED or POST: go to IDLE on the next edge and abandon the partial capture. No writes occur after that edge.
- wr_addr is a free-running counter. It increments after each write, wraps DEPTH−1→0, and is never reset between captures.
- The PREFILL, ARMED-timeout and POST counters clear on each state entry.
- trig_forced updates only on the trigger event and holds through HOLD.
- frame_done is ignored in every state except HOLD. A pulse in the same cycle HOLD is entered is ignored.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, capture_ready=0, start_addr=0, trig_forced=0, state=IDLE, prev=0.
- Write path is registered: a sample with sample_valid=1 at edge n appears as wr_en=1, wr_addr, wr_data during cycle n+1. wr_en never stays high without a new valid sample.
- Trigger compare is combinational on sample_in and prev. The state change takes effect at the same edge that accepts the trigger sample.
- capture_ready is registered from state==HOLD. It rises the cycle after the final POST write strobe and falls the cycle after leaving HOLD.
- start_addr is valid whenever capture_ready=1.
- IDLE→PREFILL, and HOLD→PREFILL on frame_done, take one edge. The first sample can be accepted on the next edge.
- Back-to-back sample_valid every cycle is supported. Gaps of any length simply stall the counters.
- Asserting reset_n mid-capture returns to reset values immediately (asynchronously).

## Test plan
Bench parameters: DW=8, AW=4 (DEPTH=16), PRE=4, AUTO_TO=20.

- Rising trigger: run=1, slope=0, level=0, ramp −8..+7 valid every cycle.
  - 4 PREFILL writes, trigger on sample 0.
  - 11 POST writes, then capture_ready=1.
  - start_addr = trig_addr−4, trig_forced=0.
- Falling trigger: slope=1, level=10, samples 20,15,11,10,5 after PREFILL.
  - Trigger on 10; the sample 11 does not trigger.
- Auto timeout: auto_mode=1, constant sample 50, level=0.
  - Forced trigger on the 20th ARMED sample; trig_forced=1; capture completes.
  - With auto_mode=0 the block stays in ARMED.
- Hold and release: frame_done pulse while in HOLD with run=1 → PREFILL next cycle and capture_ready drops.
  - Same pulse with run=0 → stays in HOLD.
  - Pulse outside HOLD → no effect.
- Abort and wrap:
  - Drop run in POST → IDLE, wr_en=0 from the next cycle.
  - Run three back-to-back captures and check wr_addr wraps 15→0 and start_addr is correct mod 16.
- Reset mid-ARMED: assert reset_n low → all outputs return to reset values immediately.
  - With sample_valid gaps of 3 cycles, counters stall and write counts are unchanged.

Source files
------------

// File: rtl/scope_trigger_ctrl.sv
// Capture sequencer for the scope sample buffer: level/slope trigger, pre/post window
// written into a circular buffer, then frozen until the display finishes a frame.
module scope_trigger_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int PRE     = 64,
  parameter int AUTO_TO = 4096
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 auto_mode,
  input  logic                 trig_slope,
  input  logic signed [DW-1:0] trig_level,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_in,
  input  logic                 frame_done,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic signed [DW-1:0] wr_data,
  output logic                 capture_ready,
  output logic [AW-1:0]        start_addr,
  output logic                 trig_forced,
  output logic [2:0]           state_o
);

  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (AUTO_TO > DEPTH) ? AUTO_TO : DEPTH;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic signed [DW-1:0] wr_data_q, wr_data_d;
  logic [AW-1:0]        start_q, start_d;
  logic                 forced_q, forced_d;
  logic                 ready_q, ready_d;
  logic                 accept, real_trig, auto_trig;

  // A sample is only taken while a capture is in progress and run is still high.
  always_comb begin
    accept    = sample_valid && run && (state_q inside {PREFILL, ARMED, POST});
    real_trig = trig_slope ? ((prev_q > trig_level) && (sample_in <= trig_level))
                           : ((prev_q < trig_level) && (sample_in >= trig_level));
    auto_trig = auto_mode && (cnt_q >= CW'(AUTO_TO - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    prev_d    = prev_q;
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = start_q;
    forced_d  = forced_q;
    ready_d   = (state_q == HOLD);

    // ptr_q is the next free slot; wr_addr presents the slot just written.
    if (accept) begin
      wr_addr_d = ptr_q;
      wr_data_d = sample_in;
      ptr_d     = ptr_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = PREFILL;
          cnt_d   = '0;
        end
      end
      PREFILL: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          prev_d = sample_in;
          if (cnt_q == CW'(PRE - 1)) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ARMED: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          prev_d = sample_in;
          if (real_trig || auto_trig) begin
            state_d  = POST;
            cnt_d    = '0;
            start_d  = ptr_q - AW'(PRE);
            forced_d = !real_trig;
          end else if (cnt_q < CW'(AUTO_TO - 1)) begin
            // Saturate so a late switch to auto mode forces on the next sample.
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      POST: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == CW'(DEPTH - PRE - 2)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (frame_done && run) begin
          state_d = PREFILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      prev_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= '0;
      forced_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      prev_q    <= prev_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      forced_q  <= forced_d;
      ready_q   <= ready_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign capture_ready = ready_q;
  assign start_addr    = start_q;
  assign trig_forced   = forced_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Self-checking bench for scope_trigger_ctrl with DEPTH=16, PRE=4, AUTO_TO=20.
module tb_scope_trigger_ctrl;

  localparam int DW = 8, AW = 4, PRE = 4, AUTO_TO = 20, DEPTH = 16;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 run = 1'b0, auto_mode = 1'b0, trig_slope = 1'b0;
  logic signed [DW-1:0] trig_level = '0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic                 frame_done = 1'b0;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 capture_ready;
  logic [AW-1:0]        start_addr;
  logic                 trig_forced;
  logic [2:0]           state_o;

  int n_checks = 0, n_errors = 0;
  int exp_addr = 0;
  int last_addr = -1;
  bit saw_wrap = 0;
  logic signed [DW-1:0] stim[$];
  logic signed [DW-1:0] exp_wq[$];

  scope_trigger_ctrl #(.DW(DW), .AW(AW), .PRE(PRE), .AUTO_TO(AUTO_TO)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .run(run), .auto_mode(auto_mode),
    .trig_slope(trig_slope), .trig_level(trig_level), .sample_valid(sample_valid),
    .sample_in(sample_in), .frame_done(frame_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .capture_ready(capture_ready), .start_addr(start_addr),
    .trig_forced(trig_forced), .state_o(state_o)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // One clock with the given sample; every strobe seen must match the next expected write.
  task automatic tick(input logic v, input logic signed [DW-1:0] d);
    logic signed [DW-1:0] e;
    sample_valid = v;
    sample_in    = d;
    @(posedge CLOCK_50);
    #1;
    sample_valid = 1'b0;
    if (wr_en === 1'b1) begin
      n_checks++;
      if (exp_wq.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wq.pop_front();
        if (wr_addr !== exp_addr[AW-1:0] || wr_data !== e) begin
          n_errors++;
          $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   wr_addr, wr_data, exp_addr, e);
        end
      end
      if (last_addr == DEPTH - 1 && wr_addr == 0) saw_wrap = 1;
      last_addr = int'(wr_addr);
      exp_addr  = (exp_addr + 1) % DEPTH;
    end
  endtask

  // Reference: index into stim of the trigger sample, scanning the armed region.
  function automatic int model_trig(input bit slope, input int level, input bit am, output bit forced);
    forced = 0;
    for (int i = PRE; i < stim.size(); i++) begin
      int p, s;
      p = int'(stim[i-1]);
      s = int'(stim[i]);
      if (slope ? (p > level && s <= level) : (p < level && s >= level)) return i;
      if (am && (i - PRE + 1) == AUTO_TO) begin
        forced = 1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) begin
      int r;
      r = int'($urandom_range(80)) - 40;
      stim.push_back(r[DW-1:0]);
    end
  endtask

  task automatic run_and_check(input string name, input bit slope, input int level,
                               input bit am, input int gap, input bit fd_last);
    int t, n_feed, exp_start;
    bit forced;
    trig_slope = slope;
    trig_level = level[DW-1:0];
    auto_mode  = am;
    t = model_trig(slope, level, am, forced);
    if (t < 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_stimulus: got no trigger in %0d samples, expected one", name, stim.size());
      return;
    end
    exp_start = (exp_addr + t - PRE) % DEPTH;
    n_feed    = t + DEPTH - PRE;
    for (int i = 0; i < n_feed; i++) begin
      for (int g = 0; g < gap; g++) tick(1'b0, 8'sd99);
      exp_wq.push_back(stim[i]);
      frame_done = fd_last && (i == n_feed - 1);
      tick(1'b1, stim[i]);
      frame_done = 1'b0;
    end
    n_checks++;
    if (state_o !== 3'd4) begin
      n_errors++; $display("FAIL %s_hold_state: got %0d expected 4", name, state_o);
    end
    tick(1'b0, 8'sd0);
    n_checks++;
    if (capture_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s_ready: got %b expected 1", name, capture_ready);
    end
    n_checks++;
    if (start_addr !== exp_start[AW-1:0]) begin
      n_errors++; $display("FAIL %s_start_addr: got %0d expected %0d", name, start_addr, exp_start);
    end
    n_checks++;
    if (trig_forced !== forced) begin
      n_errors++; $display("FAIL %s_forced: got %b expected %b", name, trig_forced, forced);
    end
    n_checks++;
    if (exp_wq.size() != 0) begin
      n_errors++; $display("FAIL %s_write_count: got %0d missing writes expected 0", name, exp_wq.size());
      exp_wq.delete();
    end
    tick(1'b1, 8'sd33);
    tick(1'b1, -8'sd33);
    n_checks++;
    if (state_o !== 3'd4 || capture_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s_hold_stays: got state=%0d ready=%b expected 4/1", name, state_o, capture_ready);
    end
  endtask

  task automatic release_hold(input string name);
    run = 1'b1;
    frame_done = 1'b1;
    tick(1'b0, 8'sd0);
    frame_done = 1'b0;
    n_checks++;
    if (state_o !== 3'd1) begin
      n_errors++; $display("FAIL %s_release: got state=%0d expected 1", name, state_o);
    end
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    tick(1'b1, 8'sd5);
    tick(1'b0, 8'sd0);
    n_checks++;
    if ({wr_en, wr_addr, wr_data, capture_ready, start_addr, trig_forced, state_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got en=%b addr=%0d data=%0d rdy=%b start=%0d forced=%b state=%0d expected all 0",
               wr_en, wr_addr, wr_data, capture_ready, start_addr, trig_forced, state_o);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'sd7);
    n_checks++;
    if (state_o !== 3'd0) begin
      n_errors++; $display("FAIL idle_no_run: got state=%0d expected 0", state_o);
    end
  endtask

  task automatic test_rising();
    run = 1'b1;
    tick(1'b0, 8'sd0);
    n_checks++;
    if (state_o !== 3'd1) begin
      n_errors++; $display("FAIL rise_enter_prefill: got state=%0d expected 1", state_o);
    end
    stim.delete();
    for (int v = -8; v <= 7; v++) stim.push_back(v[DW-1:0]);
    for (int i = 0; i < 20; i++) stim.push_back(8'sd3);
    run_and_check("rise", 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_hold_release();
    run = 1'b0;
    frame_done = 1'b1;
    tick(1'b0, 8'sd0);
    frame_done = 1'b0;
    tick(1'b0, 8'sd0);
    n_checks++;
    if (state_o !== 3'd4 || capture_ready !== 1'b1) begin
      n_errors++; $display("FAIL hold_single_shot: got state=%0d ready=%b expected 4/1", state_o, capture_ready);
    end
    run = 1'b1;
    frame_done = 1'b1;
    tick(1'b0, 8'sd0);
    frame_done = 1'b0;
    n_checks++;
    if (state_o !== 3'd1 || capture_ready !== 1'b1) begin
      n_errors++; $display("FAIL hold_release: got state=%0d ready=%b expected 1/1", state_o, capture_ready);
    end
    tick(1'b0, 8'sd0);
    n_checks++;
    if (capture_ready !== 1'b0) begin
      n_errors++; $display("FAIL ready_drop: got %b expected 0", capture_ready);
    end
  endtask

  task automatic test_falling();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'sd30);
    stim.push_back(8'sd20); stim.push_back(8'sd15); stim.push_back(8'sd11);
    stim.push_back(8'sd10); stim.push_back(8'sd5);
    for (int i = 0; i < 20; i++) stim.push_back(-8'sd4);
    run_and_check("fall", 1'b1, 10, 1'b0, 0, 1'b0);
    release_hold("fall");
  endtask

  task automatic test_auto();
    stim.delete();
    for (int i = 0; i < 60; i++) stim.push_back(8'sd50);
    run_and_check("auto", 1'b0, 0, 1'b1, 0, 1'b0);
    release_hold("auto");
    auto_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_wq.push_back(8'sd50);
      tick(1'b1, 8'sd50);
    end
    n_checks++;
    if (state_o !== 3'd2 || capture_ready !== 1'b0) begin
      n_errors++; $display("FAIL auto_off_armed: got state=%0d ready=%b expected 2/0", state_o, capture_ready);
    end
    frame_done = 1'b1;
    tick(1'b0, 8'sd0);
    frame_done = 1'b0;
    n_checks++;
    if (state_o !== 3'd2) begin
      n_errors++; $display("FAIL frame_done_armed: got state=%0d expected 2", state_o);
    end
    run = 1'b0;
    tick(1'b1, 8'sd50);
    n_checks++;
    if (state_o !== 3'd0 || wr_en !== 1'b0 || trig_forced !== 1'b1) begin
      n_errors++; $display("FAIL auto_abort: got state=%0d en=%b forced=%b expected 0/0/1", state_o, wr_en, trig_forced);
    end
  endtask

  task automatic test_abort();
    frame_done = 1'b1;
    tick(1'b0, 8'sd0);
    frame_done = 1'b0;
    n_checks++;
    if (state_o !== 3'd0) begin
      n_errors++; $display("FAIL frame_done_idle: got state=%0d expected 0", state_o);
    end
    run = 1'b1; trig_slope = 1'b0; trig_level = 8'sd0; auto_mode = 1'b0;
    tick(1'b0, 8'sd0);
    for (int i = 0; i < 8; i++) begin
      logic signed [DW-1:0] s;
      s = (i < 4) ? -8'sd5 : 8'(i);
      exp_wq.push_back(s);
      tick(1'b1, s);
    end
    n_checks++;
    if (state_o !== 3'd3) begin
      n_errors++; $display("FAIL abort_in_post: got state=%0d expected 3", state_o);
    end
    run = 1'b0;
    tick(1'b1, 8'sd9);
    n_checks++;
    if (state_o !== 3'd0 || wr_en !== 1'b0) begin
      n_errors++; $display("FAIL abort_idle: got state=%0d en=%b expected 0/0", state_o, wr_en);
    end
    tick(1'b1, 8'sd9);
    n_checks++;
    if (wr_en !== 1'b0 || exp_wq.size() != 0) begin
      n_errors++; $display("FAIL abort_no_write: got en=%b pending=%0d expected 0/0", wr_en, exp_wq.size());
    end
  endtask

  task automatic test_back_to_back();
    run = 1'b1;
    tick(1'b0, 8'sd0);
    saw_wrap = 0;
    for (int c = 0; c < 3; c++) begin
      int lv;
      lv = int'($urandom_range(40)) - 20;
      fill_random(60);
      run_and_check("b2b", 1'($urandom_range(1)), lv, 1'b1, 0, 1'b0);
      release_hold("b2b");
    end
    n_checks++;
    if (saw_wrap !== 1'b1) begin
      n_errors++; $display("FAIL addr_wrap: got wrap_seen=%b expected 1", saw_wrap);
    end
  endtask

  task automatic test_gaps();
    int lv;
    lv = int'($urandom_range(40)) - 20;
    fill_random(60);
    run_and_check("gaps", 1'($urandom_range(1)), lv, 1'b1, 3, 1'b0);
    release_hold("gaps");
  endtask

  task automatic test_reset_mid();
    auto_mode = 1'b0; trig_slope = 1'b0; trig_level = 8'sd0;
    for (int i = 0; i < 6; i++) begin
      exp_wq.push_back(8'sd50);
      tick(1'b1, 8'sd50);
    end
    n_checks++;
    if (state_o !== 3'd2) begin
      n_errors++; $display("FAIL pre_reset_armed: got state=%0d expected 2", state_o);
    end
    exp_wq.push_back(8'sd50);
    tick(1'b1, 8'sd50);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, capture_ready, start_addr, trig_forced, state_o} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%0d rdy=%b start=%0d forced=%b state=%0d expected all 0",
               wr_en, wr_addr, wr_data, capture_ready, start_addr, trig_forced, state_o);
    end
    exp_addr = 0;
    last_addr = -1;
    exp_wq.delete();
    tick(1'b0, 8'sd0);
    reset_n = 1'b1;
    tick(1'b0, 8'sd0);
    fill_random(60);
    run_and_check("after_reset", 1'b0, 0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rising();
    test_hold_release();
    test_falling();
    test_auto();
    test_abort();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
